// File: rtl/imm_narrow_packer.sv
// Packs 16-bit words into the shortest byte stream that sign-extends back.
// Short words leave as one byte; wide words leave as high then low byte.
module imm_narrow_packer #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_short,
    output logic             out_last,
    output logic [CNT_W-1:0] fit_count,
    output logic [CNT_W-1:0] wide_count
);

    typedef enum logic [1:0] {
        IDLE,
        SEND_ONE,
        SEND_HI,
        SEND_LO
    } state_e;

    state_e             state_q, state_d;
    logic [OUT_W-1:0]   lo_q, lo_d;
    logic [OUT_W-1:0]   data_q, data_d;
    logic               short_q, short_d;
    logic               last_q, last_d;
    logic [CNT_W-1:0]   fit_q, fit_d;
    logic [CNT_W-1:0]   wide_q, wide_d;

    logic [IN_W-OUT_W:0] top_bits;
    logic                fits;

    // Top IN_W-OUT_W+1 bits equal means the word is a sign-extended byte.
    assign top_bits = in_data[IN_W-1:OUT_W-1];
    assign fits     = (&top_bits) | ~(|top_bits);

    // Next-state, next output byte and saturating counter updates.
    always_comb begin
        state_d = state_q;
        lo_d    = lo_q;
        data_d  = data_q;
        short_d = short_q;
        last_d  = last_q;
        fit_d   = fit_q;
        wide_d  = wide_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    lo_d = in_data[OUT_W-1:0];
                    if (fits) begin
                        state_d = SEND_ONE;
                        data_d  = in_data[OUT_W-1:0];
                        short_d = 1'b1;
                        last_d  = 1'b1;
                    end else begin
                        state_d = SEND_HI;
                        data_d  = in_data[IN_W-1:OUT_W];
                        short_d = 1'b0;
                        last_d  = 1'b0;
                    end
                end
            end
            SEND_ONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                    data_d  = '0;
                    short_d = 1'b0;
                    last_d  = 1'b0;
                    if (fit_q != {CNT_W{1'b1}})
                        fit_d = fit_q + CNT_W'(1);
                end
            end
            SEND_HI: begin
                if (out_ready) begin
                    state_d = SEND_LO;
                    data_d  = lo_q;
                    short_d = 1'b0;
                    last_d  = 1'b1;
                end
            end
            SEND_LO: begin
                if (out_ready) begin
                    state_d = IDLE;
                    data_d  = '0;
                    short_d = 1'b0;
                    last_d  = 1'b0;
                    if (wide_q != {CNT_W{1'b1}})
                        wide_d = wide_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, latched low byte, registered outputs and counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            lo_q    <= '0;
            data_q  <= '0;
            short_q <= 1'b0;
            last_q  <= 1'b0;
            fit_q   <= '0;
            wide_q  <= '0;
        end else begin
            state_q <= state_d;
            lo_q    <= lo_d;
            data_q  <= data_d;
            short_q <= short_d;
            last_q  <= last_d;
            fit_q   <= fit_d;
            wide_q  <= wide_d;
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign out_valid  = (state_q != IDLE);
    assign out_data   = data_q;
    assign out_short  = short_q;
    assign out_last   = last_q;
    assign fit_count  = fit_q;
    assign wide_count = wide_q;

endmodule

// File: tb/tb_imm_narrow_packer.sv
// Randomised and directed bench for imm_narrow_packer.
// A byte-queue model derived from signed-range arithmetic predicts outputs.
module tb_imm_narrow_packer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [15:0] in_data;
    logic        out_valid, out_ready;
    logic [7:0]  out_data;
    logic        out_short, out_last;
    logic [7:0]  fit_count, wide_count;

    logic        in_valid2, in_ready2;
    logic [15:0] in_data2;
    logic        out_valid2;
    logic [7:0]  out_data2;
    logic        out_short2, out_last2;
    logic [1:0]  fit_count2, wide_count2;

    int n_chk = 0;
    int n_pass = 0;

    typedef struct {
        logic [7:0] d;
        logic       s;
        logic       l;
    } byte_t;

    byte_t q[$];
    int    fits_m;
    int    wides_m;

    always #5 clk = ~clk;

    imm_narrow_packer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_short  (out_short),
        .out_last   (out_last),
        .fit_count  (fit_count),
        .wide_count (wide_count)
    );

    imm_narrow_packer #(.CNT_W(2)) dut2 (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid2),
        .in_ready   (in_ready2),
        .in_data    (in_data2),
        .out_valid  (out_valid2),
        .out_ready  (1'b1),
        .out_data   (out_data2),
        .out_short  (out_short2),
        .out_last   (out_last2),
        .fit_count  (fit_count2),
        .wide_count (wide_count2)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic check_outputs();
        check("in_ready", 32'(in_ready), 32'(q.size() == 0));
        check("out_valid", 32'(out_valid), 32'(q.size() != 0));
        if (q.size() != 0) begin
            check("out_data", 32'(out_data), 32'(q[0].d));
            check("out_short", 32'(out_short), 32'(q[0].s));
            check("out_last", 32'(out_last), 32'(q[0].l));
        end
        check("fit_count", 32'(fit_count), 32'(fits_m));
        check("wide_count", 32'(wide_count), 32'(wides_m));
    endtask

    task automatic push_word(input logic [15:0] w);
        int sv;
        sv = int'($signed(w));
        if (sv >= -128 && sv <= 127) begin
            q.push_back('{w[7:0], 1'b1, 1'b1});
        end else begin
            q.push_back('{w[15:8], 1'b0, 1'b0});
            q.push_back('{w[7:0], 1'b0, 1'b1});
        end
    endtask

    // Called at a negedge: check, drive, advance model, wait one cycle.
    task automatic cycle(input logic v, input logic [15:0] d,
                         input logic r);
        byte_t b;
        check_outputs();
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        if (q.size() != 0) begin
            if (r) begin
                b = q.pop_front();
                if (b.l && b.s) fits_m = (fits_m < 255) ? fits_m + 1 : 255;
                if (b.l && !b.s) wides_m = (wides_m < 255) ? wides_m + 1 : 255;
            end
        end else if (v) begin
            push_word(d);
        end
        @(negedge clk);
    endtask

    function automatic logic [15:0] rand_word();
        logic [15:0] w;
        logic [7:0]  b;
        int          k;
        k = $urandom_range(0, 3);
        b = 8'($urandom);
        if (k == 0) w = {{8{b[7]}}, b};
        else if (k == 1) w = 16'($urandom);
        else if (k == 2) w = {{7{b[7]}}, ~b[7], b};
        else w = 16'($urandom_range(0, 1) ? 16'hFF80 : 16'h007F);
        return w;
    endfunction

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        in_valid2 = 1'b0;
        in_data2  = '0;
        fits_m    = 0;
        wides_m   = 0;
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_short_last", 32'({out_short, out_last}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        cycle(1'b1, 16'hFFAA, 1'b1);
        check("t1_byte", 32'({out_data, out_short, out_last}),
              32'({8'hAA, 2'b11}));
        cycle(1'b0, 16'h0000, 1'b1);
        cycle(1'b1, 16'h007F, 1'b1);
        cycle(1'b1, 16'h0080, 1'b1);
        cycle(1'b0, 16'h0000, 1'b1);
        cycle(1'b1, 16'h0080, 1'b1);
        cycle(1'b0, 16'h0000, 1'b1);
        cycle(1'b0, 16'h0000, 1'b1);
        cycle(1'b1, 16'hFF7F, 1'b1);
        cycle(1'b0, 16'h0000, 1'b1);
        cycle(1'b0, 16'h0000, 1'b1);

        cycle(1'b1, 16'h1234, 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b1, 16'h5555, 1'b0);
        check("t4_hold", 32'(out_data), 32'h12);
        cycle(1'b0, 16'h0000, 1'b1);
        check("t4_lo", 32'(out_data), 32'h34);
        cycle(1'b0, 16'h0000, 1'b1);

        cycle(1'b1, 16'h1234, 1'b0);
        rst_n = 1'b0;
        #1;
        check("t5_out_valid", 32'(out_valid), 32'd0);
        check("t5_out_data", 32'(out_data), 32'd0);
        check("t5_counts", 32'({fit_count, wide_count}), 32'd0);
        q.delete();
        fits_m  = 0;
        wides_m = 0;
        @(negedge clk);
        cycle(1'b0, 16'h0000, 1'b1);
        rst_n = 1'b1;
        cycle(1'b0, 16'h0000, 1'b1);
        cycle(1'b0, 16'h0000, 1'b1);
        cycle(1'b1, 16'hFFF0, 1'b1);
        cycle(1'b0, 16'h0000, 1'b1);

        for (int i = 0; i < 600; i++) begin
            cycle(1'($urandom_range(0, 3) != 0), rand_word(),
                  1'($urandom_range(0, 9) < 7));
        end
        for (int i = 0; i < 6; i++) cycle(1'b0, 16'h0000, 1'b1);
        check_outputs();

        for (int k = 1; k <= 5; k++) begin
            in_valid2 = 1'b1;
            in_data2  = 16'($urandom_range(0, 127));
            @(negedge clk);
            in_valid2 = 1'b0;
            check("sat_byte", 32'({out_valid2, out_short2, out_last2}),
                  32'd7);
            @(negedge clk);
            check("sat_fit", 32'(fit_count2), 32'((k < 3) ? k : 3));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
